// File: rtl/fpu_resp_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_resp_buffer
// Brief    : Credit-gated response FIFO that makes a non-stallable FPU result
//            port safe to backpressure with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_resp_buffer #(
    parameter int ID_WIDTH        = 9,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    // request side
    input  logic                       req_i,
    output logic                       gnt_o,
    output logic                       fpu_req_o,
    input  logic                       fpu_gnt_i,
    // FPU result side (cannot be stalled)
    input  logic                       fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      fpu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0] fpu_rflags_i,
    input  logic [ID_WIDTH-1:0]        fpu_rID_i,
    // buffered response side
    output logic                       rvalid_o,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0] rflags_o,
    output logic [ID_WIDTH-1:0]        rID_o,
    input  logic                       rready_i,
    // status
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       overflow_o
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    typedef struct packed {
        logic [ID_WIDTH-1:0]        id;
        logic [DATA_WIDTH-1:0]      data;
        logic [FLAGS_OUT_WIDTH-1:0] flags;
    } entry_t;

    entry_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_outstanding;
    logic                 r_overflow;

    logic                 w_credit_ok;
    logic                 w_issue;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push_ok;
    logic                 w_drop;
    logic                 w_not_empty;
    entry_t               w_head;

    assign w_credit_ok = (r_outstanding < c_DEPTH_CNT);
    assign fpu_req_o   = req_i & w_credit_ok;
    assign gnt_o       = fpu_gnt_i & w_credit_ok;
    assign w_issue     = fpu_req_o & fpu_gnt_i;

    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_not_empty & rready_i;
    assign w_full      = (r_count == c_DEPTH_CNT);
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign w_push_ok   = fpu_rvalid_i & (~w_full | w_pop);
    assign w_drop      = fpu_rvalid_i & w_full & ~w_pop;

    // Credits are returned on consumer pop, not on FPU completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - c_CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= '{id: fpu_rID_i, data: fpu_rdata_i, flags: fpu_rflags_i};
        end
    end

    assign w_head        = w_not_empty ? r_mem[r_rd_ptr] : '0;
    assign rvalid_o      = w_not_empty;
    assign rdata_o       = w_head.data;
    assign rflags_o      = w_head.flags;
    assign rID_o         = w_head.id;
    assign outstanding_o = r_outstanding;
    assign overflow_o    = r_overflow;

endmodule
`default_nettype wire
